// File: rtl/note_lane_scroller.sv
// Scrolling note-lane renderer: raster scan with per-pixel colour, tick-driven row scroll,
// and optional key hit/miss judging enabled by defining HIT_JUDGE_EN.
module note_lane_scroller #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned ROWS      = 11,
  parameter int unsigned ROW_PITCH = 20,
  parameter int unsigned NOTE_H    = 10,
  parameter int unsigned STEP_PX   = 4,
  parameter int unsigned TICK_DIV  = 1000000,
  parameter int unsigned WIDTH     = 320,
  parameter int unsigned HEIGHT    = 240,
  parameter int unsigned LANE_X0   = 125,
  parameter int unsigned LANE_W    = 16,
  parameter int unsigned HIT_Y     = 220
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] note_data,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [LANES-1:0] key,
  output logic [8:0]       x,
  output logic [7:0]       y,
  output logic [2:0]       colour,
  output logic [LANES-1:0] hit,
  output logic [LANES-1:0] miss,
  output logic [15:0]      score
);

  localparam int unsigned TW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned OW     = $clog2(ROW_PITCH + STEP_PX + 1);
  localparam int unsigned LANE_P = LANE_W + 2;

  logic [TW-1:0]    tick_cnt;
  logic [OW-1:0]    offset;
  logic [LANES-1:0] rows [ROWS];
  logic             tick;
  logic             advance;
  logic [8:0]       nx;
  logic [7:0]       ny;
  logic [2:0]       ncolour;

  function automatic logic [2:0] lane_colour(input int unsigned l);
    case (l % 4)
      0:       lane_colour = 3'b100;
      1:       lane_colour = 3'b011;
      2:       lane_colour = 3'b110;
      default: lane_colour = 3'b101;
    endcase
  endfunction

  assign tick       = (tick_cnt == TW'(TICK_DIV - 1));
  assign advance    = tick && (32'(offset) + STEP_PX >= ROW_PITCH);
  assign note_ready = advance && !reset;

  always_comb begin
    nx = x + 9'd1;
    ny = y;
    if (x == 9'(WIDTH - 1)) begin
      nx = '0;
      ny = (y == 8'(HEIGHT - 1)) ? '0 : y + 8'd1;
    end
  end

  // Colour is computed for the next scan position and registered with it, so x/y/colour stay aligned.
  always_comb begin
    ncolour = 3'b111;
    for (int unsigned l = 0; l <= LANES; l++)
      if (32'(nx) + 2 >= LANE_X0 + l*LANE_P && 32'(nx) < LANE_X0 + l*LANE_P)
        ncolour = '0;
    for (int unsigned l = 0; l < LANES; l++)
      if (32'(nx) >= LANE_X0 + l*LANE_P && 32'(nx) < LANE_X0 + l*LANE_P + LANE_W) begin
        if (32'(ny) == HIT_Y || 32'(ny) == HIT_Y + 1)
          ncolour = '0;
        else if (32'(ny) < HIT_Y)
          for (int unsigned r = 0; r < ROWS; r++)
            if (rows[r][l] && 32'(ny) >= r*ROW_PITCH + 32'(offset)
                && 32'(ny) < r*ROW_PITCH + 32'(offset) + NOTE_H)
              ncolour = lane_colour(l);
      end
  end

`ifdef HIT_JUDGE_EN
  logic [LANES-1:0] key_q;
  logic [LANES-1:0] key_edge;
  logic [LANES-1:0] hit_now;
  logic [LANES-1:0] miss_now;
  logic [15:0]      score_next;

  // Judging uses the pre-shift bottom row; a note hit on an advance cycle is not also missed.
  always_comb begin
    key_edge   = key & ~key_q;
    hit_now    = key_edge & rows[ROWS-1];
    miss_now   = key_edge & ~rows[ROWS-1];
    if (advance)
      miss_now = miss_now | (rows[ROWS-1] & ~hit_now);
    score_next = score;
    for (int unsigned l = 0; l < LANES; l++)
      if (hit_now[l] && score_next != 16'hFFFF)
        score_next = score_next + 16'd1;
  end

  always_ff @(posedge clk) begin
    key_q <= key;
    if (reset) begin
      hit   <= '0;
      miss  <= '0;
      score <= '0;
    end else begin
      hit   <= hit_now;
      miss  <= miss_now;
      score <= score_next;
    end
  end
`else
  logic unused_key;
  assign unused_key = ^key;
  assign hit   = '0;
  assign miss  = '0;
  assign score = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      tick_cnt <= '0;
      offset   <= '0;
      for (int unsigned r = 0; r < ROWS; r++)
        rows[r] <= '0;
    end else begin
      x        <= nx;
      y        <= ny;
      colour   <= ncolour;
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (advance) begin
        offset <= '0;
        for (int unsigned r = ROWS - 1; r > 0; r--)
          rows[r] <= rows[r-1];
        rows[0] <= note_valid ? note_data : '0;
      end else begin
        if (tick)
          offset <= offset + OW'(STEP_PX);
`ifdef HIT_JUDGE_EN
        rows[ROWS-1] <= rows[ROWS-1] & ~hit_now;
`endif
      end
    end
  end

endmodule

// File: tb/tb_note_lane_scroller.sv
// Directed bench for note_lane_scroller with TICK_DIV=4; judging checks depend on HIT_JUDGE_EN.
module tb_note_lane_scroller;

  logic       clk;
  logic       reset;
  logic [3:0] note_data;
  logic       note_valid;
  logic       note_ready;
  logic [3:0] key;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] colour;
  logic [3:0] hit;
  logic [3:0] miss;
  logic [15:0] score;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned scan_err = 0;
  logic        frame_watch = 1'b0;

  note_lane_scroller #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .note_data(note_data), .note_valid(note_valid),
    .note_ready(note_ready), .key(key), .x(x), .y(y), .colour(colour),
    .hit(hit), .miss(miss), .score(score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // State index: number of clock edges since reset was released.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  always @(negedge clk)
    if (frame_watch && !reset && cyc < 76800)
      if (32'(x) != cyc % 320 || 32'(y) != cyc / 320)
        scan_err++;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (state %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic wait_state(input int unsigned n);
    int unsigned guard = 0;
    while (cyc != n && guard < 200000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("wait_state", cyc, n);
  endtask

  function automatic logic [3:0] rows_or();
    logic [3:0] acc = '0;
    for (int r = 0; r < 11; r++) acc = acc | dut.rows[r];
    return acc;
  endfunction

  initial begin
    reset = 1'b1; note_data = '0; note_valid = 1'b0; key = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_x", 32'(x), 0);
    check_eq("rst_y", 32'(y), 0);
    check_eq("rst_colour", 32'(colour), 0);
    check_eq("rst_ready", 32'(note_ready), 0);
    check_eq("rst_offset", 32'(dut.offset), 0);
    check_eq("rst_hit_miss", {hit, miss}, 0);
    check_eq("rst_score", 32'(score), 0);
    reset = 1'b0;
    frame_watch = 1'b1;

    wait_state(4);  check_eq("offset_4", 32'(dut.offset), 4);
    wait_state(8);  check_eq("offset_8", 32'(dut.offset), 8);
    wait_state(12); check_eq("offset_12", 32'(dut.offset), 12);
    wait_state(16); check_eq("offset_16", 32'(dut.offset), 16);
    wait_state(18); check_eq("ready_before", 32'(note_ready), 0);
    wait_state(19); check_eq("ready_adv1", 32'(note_ready), 1);
    note_valid = 1'b1; note_data = 4'b0001;
    wait_state(20);
    check_eq("ready_after", 32'(note_ready), 0);
    check_eq("offset_wrap", 32'(dut.offset), 0);
    check_eq("row0_load", 32'(dut.rows[0]), 4'b0001);
    note_valid = 1'b0; note_data = 4'b1111;
    wait_state(39); check_eq("ready_adv2", 32'(note_ready), 1);
    wait_state(40);
    check_eq("row0_invalid", 32'(dut.rows[0]), 0);
    check_eq("row1_shift", 32'(dut.rows[1]), 4'b0001);
    note_data = '0;
    wait_state(220);
    check_eq("row10_note", 32'(dut.rows[10]), 4'b0001);
    check_eq("row10_offset", 32'(dut.offset), 0);
    wait_state(240);
`ifdef HIT_JUDGE_EN
    check_eq("shiftout_miss", 32'(miss), 4'b0001);
`else
    check_eq("shiftout_nomiss", 32'(miss), 0);
`endif
    wait_state(241); check_eq("miss_pulse_end", 32'(miss), 0);

    wait_state(259); note_valid = 1'b1; note_data = 4'b0001;
    wait_state(260); note_valid = 1'b0; note_data = '0;
    wait_state(465); key = 4'b0001;
    wait_state(466);
`ifdef HIT_JUDGE_EN
    check_eq("hit0", 32'(hit), 4'b0001);
    check_eq("hit0_score", 32'(score), 1);
`else
    check_eq("hit0_off", 32'(hit), 0);
    check_eq("score_off", 32'(score), 0);
`endif
    check_eq("hit0_nomiss", 32'(miss), 0);
    wait_state(467); check_eq("hit_pulse_end", 32'(hit), 0);
    wait_state(470); key = '0;
    wait_state(480); check_eq("hit_no_shiftout", 32'(miss), 0);
    wait_state(500); key = 4'b0010;
    wait_state(501);
`ifdef HIT_JUDGE_EN
    check_eq("empty_key_miss", 32'(miss), 4'b0010);
`else
    check_eq("empty_key_off", 32'(miss), 0);
`endif
    check_eq("empty_key_nohit", 32'(hit), 0);
    wait_state(505); key = '0;
    wait_state(519); note_valid = 1'b1; note_data = 4'b0100;
    wait_state(520); note_valid = 1'b0; note_data = '0;
    wait_state(739); key = 4'b0100;
    wait_state(740);
`ifdef HIT_JUDGE_EN
    check_eq("adv_hit", 32'(hit), 4'b0100);
    check_eq("adv_score", 32'(score), 2);
`else
    check_eq("adv_hit_off", 32'(hit), 0);
`endif
    check_eq("adv_nomiss", 32'(miss), 0);
    wait_state(745); key = '0;

    wait_state(16122); check_eq("px_outside", 32'(colour), 3'b111);
    wait_state(16123); check_eq("px_left_border", 32'(colour), 3'b000);
    wait_state(32196); check_eq("px_right_border", 32'(colour), 3'b000);
    wait_state(32197); check_eq("px_past_border", 32'(colour), 3'b111);
    wait_state(65199); note_valid = 1'b1; note_data = 4'b0001;
    wait_state(65200); note_valid = 1'b0; note_data = '0;
    wait_state(65404); check_eq("px_note_border", 32'(colour), 3'b000);
    wait_state(65405); check_eq("px_note_lane0", 32'(colour), 3'b100);
    wait_state(65420); check_eq("px_note_moved", 32'(colour), 3'b111);
    wait_state(70525); check_eq("px_hit_line", 32'(colour), 3'b000);
    wait_state(70920); check_eq("px_hit_outside", 32'(colour), 3'b111);
    wait_state(73730); check_eq("px_below_hit", 32'(colour), 3'b111);

    wait_state(76799); note_valid = 1'b1; note_data = 4'b1111;
    wait_state(76800);
    note_valid = 1'b0; note_data = '0;
    frame_watch = 1'b0;
    check_eq("frame_x", 32'(x), 0);
    check_eq("frame_y", 32'(y), 0);
    check_eq("frame_scan", scan_err, 0);

    wait_state(76819);
    check_eq("pre_rst_rows", 32'(dut.rows[0]), 4'b1111);
    check_eq("pre_rst_ready", 32'(note_ready), 1);
    reset = 1'b1;
    #1;
    check_eq("rst_gates_ready", 32'(note_ready), 0);
    @(negedge clk);
    check_eq("mid_rst_rows", 32'(rows_or()), 0);
    check_eq("mid_rst_offset", 32'(dut.offset), 0);
    check_eq("mid_rst_tick", 32'(dut.tick_cnt), 0);
    check_eq("mid_rst_xy", {x, y}, 0);
    check_eq("mid_rst_colour", 32'(colour), 0);
    check_eq("mid_rst_score", 32'(score), 0);
    check_eq("mid_rst_hit_miss", {hit, miss}, 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_x", 32'(x), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/note_lane_scroller.md
NOTE_LANE_SCROLLER -- requirements
Module: note_lane_scroller

Interface
REQ-001 SHALL take parameter LANES, default 4: number of note lanes (1..8).
REQ-002 SHALL take parameter ROWS, default 11: number of note rows held on screen.
REQ-003 SHALL take parameter ROW_PITCH, default 20: pixel pitch between rows.
REQ-004 SHALL take parameter NOTE_H, default 10: note height in pixels.
REQ-005 SHALL take parameter STEP_PX, default 4: pixels moved per scroll tick.
REQ-006 SHALL take parameter TICK_DIV, default 1000000: clk cycles per scroll tick.
REQ-007 SHALL take parameters WIDTH 320, HEIGHT 240, LANE_X0 125, LANE_W 16, HIT_Y 220: screen size, first lane left x, lane width, hit-line y.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port note_data, input, LANES bits: next row pattern, bit l = lane l.
REQ-011 SHALL have port note_valid, input, 1 bit: note_data is valid.
REQ-012 SHALL have port note_ready, output, 1 bit: row-load strobe.
REQ-013 SHALL have port key, input, LANES bits: player buttons, already synchronised.
REQ-014 SHALL have ports x (9 bits), y (8 bits) and colour (3 bits), all outputs: pixel scan position and its colour.
REQ-015 SHALL have ports hit and miss, outputs, LANES bits each: one-cycle judgement pulses.
REQ-016 SHALL have port score, output, 16 bits: count of hits.

Function
REQ-017 SHALL scan x over 0..WIDTH-1, advancing once per clk; at x = WIDTH-1, x wraps to 0 and y advances; y wraps from HEIGHT-1 to 0.
REQ-018 SHALL present colour for the same (x,y) that is output in the same cycle.
REQ-019 SHALL place lane l at x in [LANE_X0 + l*(LANE_W+2), +LANE_W-1], bounded on each side by 2-pixel black (000) borders.
REQ-020 SHALL draw y = HIT_Y and HIT_Y+1 as black within lanes; all other background SHALL be white (111).
REQ-021 SHALL draw row r, lane l in lane colour C[l] (lanes 0..3: 100, 011, 110, 101, repeating) for y in [r*ROW_PITCH+offset, +NOTE_H-1], only when its bit is set and y < HIT_Y.
REQ-022 SHALL count tick_cnt 0..TICK_DIV-1, producing a tick on the wrap cycle.
REQ-023 SHALL, on a tick with offset+STEP_PX < ROW_PITCH, set offset += STEP_PX; otherwise perform a row advance.
REQ-024 SHALL, on a row advance, set offset to 0 and shift row r to r+1, discarding row ROWS-1.
REQ-025 SHALL, on a row advance, assert note_ready for exactly that cycle and load row 0 with note_data if note_valid is high, else with all zeros; note_data is never held.
REQ-026 SHALL not change the rows or offset mid-frame tearing rules: updates apply immediately and no frame sync is required.

Reset
REQ-027 SHALL, on reset, clear x, y, colour, tick_cnt, offset, all rows, note_ready, hit, miss and score to 0.
REQ-028 SHALL give reset priority over all other events, including a tick in the same cycle.

Configuration
REQ-029 SHALL, with HIT_JUDGE_EN defined, register key and detect rising edges per lane.
REQ-030 SHALL, with HIT_JUDGE_EN defined, respond to a key edge on lane l: if row ROWS-1 bit l is set, pulse hit[l], clear that bit and increment score (saturating at 65535); otherwise pulse miss[l].
REQ-031 SHALL, with HIT_JUDGE_EN defined, pulse miss[l] on each row advance for which the discarded row ROWS-1 bit l is still set.
REQ-032 SHALL, with HIT_JUDGE_EN defined, judge a key edge coinciding with a row advance against the pre-shift row; a hit suppresses the shift-out miss for that note.
REQ-033 SHALL, without HIT_JUDGE_EN, ignore key and hold hit, miss and score at 0.

Verification
REQ-034 SHALL check: reset, then 320*240 clocks -> x,y return to 0,0 and y counts 0..239 exactly once.
REQ-035 SHALL check: TICK_DIV=4 with defaults -> offset steps 0,4,8,12,16, then a row advance with a one-cycle note_ready on the 5th tick.
REQ-036 SHALL check: note_valid=1, note_data=0001 at an advance -> after 10 further advances, lane 0 drawn at y=200..209 with colour 100.
REQ-037 SHALL check: note_valid=0 at an advance -> row 0 becomes 0000.
REQ-038 SHALL check (HIT_JUDGE_EN): key[0] edge with row 10 bit 0 set -> hit[0] pulse, score=1, no miss at the next advance.
REQ-039 SHALL check (HIT_JUDGE_EN): an unplayed note shifted out -> miss[l] pulse; reset asserted mid-scroll -> all rows cleared the next cycle.
